// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/register encodings and sequencer state type shared by the CPU blocks.
package cpu_pkg;
    localparam logic [1:0] OPC_ALU = 2'b01;
    localparam logic [1:0] OPC_MOV = 2'b11;
    localparam logic [2:0] REG_IO  = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WAIT_IN,
        WAIT_OUT,
        WRITEBACK,
        FAULT
    } seq_state_t;
endpackage

// File: rtl/io_wait_timer.sv
// io_wait_timer: 8-bit clear/increment counter; expired flags the increment that reaches IO_WAIT_MAX.
module io_wait_timer #(
    parameter int IO_WAIT_MAX = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    logic [7:0] count;

    always_ff @(posedge clock or negedge reset)
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (inc) count <= count + 8'd1;

    assign expired = inc && (count == 8'(IO_WAIT_MAX - 1));
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: four-phase fetch/decode/execute/writeback sequencer with run/step control
// and valid/ready wait states for I/O-register moves.
module cycle_sequencer
    import cpu_pkg::*;
#(
    parameter int IO_WAIT_MAX   = 255,
    parameter int RETIRED_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     step,
    input  logic [1:0]               opcode,
    input  logic [2:0]               arg0,
    input  logic [2:0]               arg1,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     fetch,
    output logic                     decode,
    output logic                     execute,
    output logic                     writeback,
    output logic                     busy,
    output logic                     fault,
    output logic [RETIRED_WIDTH-1:0] retired
);
    seq_state_t state, nxt;
    logic step_q, step_edge, hs_in, hs_out, expired;

    assign step_edge = step && !step_q;
    assign hs_in     = (state == WAIT_IN) && in_valid && in_ready;
    assign hs_out    = (state == WAIT_OUT) && out_valid && out_ready;

    io_wait_timer #(.IO_WAIT_MAX(IO_WAIT_MAX)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == EXECUTE),
        .inc     ((state == WAIT_IN && !hs_in) || (state == WAIT_OUT && !hs_out)),
        .expired (expired)
    );

    // A handshake in the cycle the timer expires still completes the move.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = (enable || step_edge) ? FETCH : IDLE;
            FETCH:     nxt = DECODE;
            DECODE:    nxt = EXECUTE;
            EXECUTE:   nxt = (opcode == OPC_MOV && arg0 == REG_IO) ? WAIT_OUT :
                             (opcode == OPC_MOV && arg1 == REG_IO) ? WAIT_IN : WRITEBACK;
            WAIT_IN:   nxt = hs_in ? WRITEBACK : expired ? FAULT : WAIT_IN;
            WAIT_OUT:  nxt = hs_out ? WRITEBACK : expired ? FAULT : WAIT_OUT;
            WRITEBACK: nxt = enable ? FETCH : IDLE;
            default:   nxt = FAULT;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step_q    <= 1'b0;
            fetch     <= 1'b0;
            decode    <= 1'b0;
            execute   <= 1'b0;
            writeback <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            retired   <= '0;
        end else begin
            state     <= nxt;
            step_q    <= step;
            fetch     <= nxt == FETCH;
            decode    <= nxt == DECODE;
            execute   <= nxt == EXECUTE;
            writeback <= nxt == WRITEBACK;
            in_ready  <= nxt == WAIT_IN;
            out_valid <= nxt == WAIT_OUT;
            busy      <= nxt != IDLE && nxt != FAULT;
            fault     <= nxt == FAULT;
            retired   <= retired + RETIRED_WIDTH'(state == WRITEBACK);
        end
    end
endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Synchronous four-phase instruction sequencer that replaces the CPU's free-running phase decoder. It issues one-cycle fetch/decode/execute/writeback strobes to the program counter, controller, ALU/conditional unit and register file. It supports run/halt via `enable` and single-stepping via `step`, and inserts valid/ready wait states for I/O-register moves. It sits between the CPU clock/reset and every phase-clocked datapath unit, with the controller feeding it back the decoded opcode and arguments.

## Interface
Parameters:
- `IO_WAIT_MAX`, 255: maximum cycles spent in an I/O wait state before faulting; legal range 1..255.
- `RETIRED_WIDTH`, 16: width of retired-instruction counter.

Ports:
- `clock`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 1 = run continuously.
- `step`  in  1  single-step request; rising edge (registered-previous detect) starts one instruction when idle.
- `opcode`  in  2  decoded opcode from controller, valid from DECODE's following cycle onward.
- `arg0`  in  3  destination register field.
- `arg1`  in  3  source register field.
- `in_valid`  in  1  external input data present.
- `in_ready`  out  1  sequencer accepting input byte.
- `out_valid`  out  1  `cpuout` holds valid data.
- `out_ready`  in  1  external sink accepted output byte.
- `fetch`, `decode`, `execute`, `writeback`  out  1 each  one-cycle phase strobes.
- `busy`  out  1  instruction in flight (any state except IDLE/FAULT).
- `fault`  out  1  I/O wait timed out; sticky until reset.
- `retired`  out  RETIRED_WIDTH  instructions completed; wraps to 0.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WAIT_IN, WAIT_OUT, WRITEBACK, FAULT.
- IDLE → FETCH when `enable`=1 or step edge; otherwise stay.
- FETCH → DECODE → EXECUTE unconditionally.
- EXECUTE classification (I/O register index 3'b110):
  - `opcode`=2'b11 and `arg0`=3'b110 → WAIT_OUT (output move; takes priority when `arg1` also = 3'b110).
  - `opcode`=2'b11 and `arg1`=3'b110 → WAIT_IN.
  - else → WRITEBACK.
- WAIT_IN: `in_ready`=1; on `in_valid`&&`in_ready` → WRITEBACK.
- WAIT_OUT: `out_valid`=1; on `out_valid`&&`out_ready` → WRITEBACK.
- Wait timer cleared on entering a wait state, increments each wait cycle without handshake; reaching IO_WAIT_MAX → FAULT. Handshake in the same cycle the timer hits max wins (→ WRITEBACK).
- WRITEBACK: `retired` += 1 (wraps); → FETCH if `enable`=1, else IDLE.
- FAULT: all strobes/handshakes 0, `fault`=1; exits only via reset.
- `enable` dropped mid-instruction: instruction completes through WRITEBACK, then IDLE. Step edges while busy ignored (not queued).

## Timing
- Reset (async assert): state IDLE; all strobes, `in_ready`, `out_valid`, `busy`, `fault` = 0; `retired` = 0; step-edge register = 0.
- Strobes are registered Moore outputs: high exactly during their state's cycle; `execute` not reasserted during wait states.
- Non-I/O instruction: 4 cycles, back-to-back with no bubble while `enable`=1.
- I/O instruction: 4 + N cycles, N = wait cycles until handshake (≥1).
- Step from IDLE: FETCH strobe the cycle after the edge is sampled.

## Structure
- Shared `cpu_pkg`: `OPC_ALU`=2'b01, `OPC_MOV`=2'b11, `REG_IO`=3'b110, state enum `seq_state_t`; the output logic of the CPU top-level bus and this block both use it.
- One sub-module: `io_wait_timer` (8-bit clear/increment counter with `expired` flag at IO_WAIT_MAX).

## Test plan
- Reset then `enable`=1, opcode 2'b01 → strobes F,D,E,W on cycles 1–4, F again on cycle 5; `retired`=1 after first W.
- `enable`=0, one `step` pulse → exactly one F/D/E/W sequence, back to IDLE, `retired`=1; step held high 10 cycles still yields one instruction.
- opcode 2'b11, arg1=3'b110, `in_valid` raised 3 cycles after WAIT_IN entry → `in_ready` high 4 cycles, W next cycle, total 8 cycles.
- opcode 2'b11, arg0=arg1=3'b110 → WAIT_OUT taken (`out_valid`=1, `in_ready`=0).
- IO_WAIT_MAX=4, `out_ready` held 0 → FAULT after 4 wait cycles, `fault`=1, no strobes; `reset` low clears to IDLE.
- `reset` asserted during WAIT_IN → all outputs 0 immediately (asynchronous), `retired`=0.
